pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core. Generates the halt (stall) and taken_branch (flush) controls
//  consumed by the fetch, decode and execute stages. Tracks in-flight destination registers (EX/MEM/WB)
//  against decode source registers. Sequences multi-cycle branch flushes and memory-busy freezes.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles taken_branch is held after a taken branch/jump (1..7)
//  CNT_W         32  width of the stall_cycles performance counter
// PORTS
//  clk           in   1      core clock; all state on rising edge
//  rst           in   1      synchronous, active-low reset
//  id_instr      in   XLEN   instruction in decode
//  id_valid      in   1      id_instr is a real instruction (0 = bubble)
//  ex_branch_en  in   1      execute stage resolved a taken BRANCH/JAL/JALR this cycle
//  mem_busy      in   1      data memory not ready; whole pipe must freeze
//  halt          out  1      stall fetch/decode/execute registers (Mealy, same cycle)
//  taken_branch  out  1      kill younger instructions (from state, registered)
//  ex_bubble     out  1      a bubble is inserted into EX this cycle
//  stall_cycles  out  CNT_W  count of cycles with halt=1, saturating
// BEHAVIOUR
//  Decode: rs1 is used by OP/OP_IMM/BRANCH/LOAD/STORE/JALR. rs2 is used by OP/BRANCH/STORE.
//   rd is written by OP/OP_IMM/LUI/AUIPC/JAL/JALR/LOAD. Opcode macros come from define.sv. x0 never hazards.
//  Tracker: 3 entries {valid,rd,is_load} for EX, MEM and WB. Entries shift EX->MEM->WB->drop each cycle unless mem_busy.
//   EX loads the decoded id_instr only when id_valid, not hazard and state==RUN. Otherwise EX loads valid=0.
//  Hazard: a used source reg of id_instr equals the rd of a valid tracker entry (see CONFIGURATION).
//  FSM states: RUN, FLUSH.
//   RUN -> FLUSH when ex_branch_en=1 and mem_busy=0. The flush counter is loaded with FLUSH_CYCLES-1.
//   FLUSH counts down each non-busy cycle and returns to RUN in the cycle after the counter reaches 0.
//   ex_branch_en is ignored in FLUSH. Those instructions are being killed.
//  Outputs:
//   taken_branch = (state==FLUSH), for exactly FLUSH_CYCLES non-busy cycles after the branch cycle.
//   halt = mem_busy | (state==RUN & id_valid & hazard) | (state==FLUSH).
//   ex_bubble = !mem_busy & (EX loads valid=0 while id_valid | state==FLUSH).
//  Priority: rst > mem_busy > ex_branch_en > hazard.
//   mem_busy freezes the tracker, FSM and flush counter. halt=1 and taken_branch holds its value.
//   Branch and hazard in the same cycle: the branch wins. The stalled decode instruction is flushed, not replayed.
//  stall_cycles increments on each cycle with halt=1 and saturates at all-ones (no wrap).
//  Reset values: state=RUN, tracker all invalid, counter=0, taken_branch=0, stall_cycles=0.
//   ex_bubble=0 and halt=mem_busy.
//  Reset asserted mid-flush or mid-stall aborts immediately. No pending flush survives reset.
// CONFIGURATION
//  HAZARD_FORWARD_EN defined:
//   The EX/MEM bypass exists, so only load-use is a hazard: a source matches EX with is_load=1. 1-cycle stall.
//  HAZARD_FORWARD_EN undefined:
//   Any source match against EX, MEM or WB is a hazard. The stall lasts until the producer leaves WB (up to 3 cycles).
// STRUCTURE
//  Package hazard_pkg holds:
//   ctrl_state_e {RUN, FLUSH}
//   trk_entry_t struct {valid, rd[4:0], is_load}
//   function uses_rs1/uses_rs2/writes_rd(opcode)
//  Sub-module hazard_scoreboard holds the 3-entry tracker and the compare logic and outputs hazard.
//  The FSM, counters and output logic stay in the top.
// TESTING
//  1. rst=0 for 2 clks, mem_busy=0 -> halt=0, taken_branch=0, stall_cycles=0, tracker empty.
//  2. LW x5,0(x1) then ADD x6,x5,x2 (FORWARD_EN) -> halt=1 for 1 cycle, ex_bubble=1, stall_cycles=1.
//  3. Same stream without FORWARD_EN -> halt=1 for 3 cycles, then ADD enters EX. ADDI x0 producer -> no stall.
//  4. ex_branch_en pulse, FLUSH_CYCLES=2 -> taken_branch=1 for the next 2 cycles.
//     A second ex_branch_en inside the window has no effect.
//  5. mem_busy=1 for 4 cycles during FLUSH -> taken_branch held, counter frozen, flush resumes,
//     stall_cycles advances by 4 plus the flush cycles.
//  6. Force stall_cycles to all-ones minus 1, hold halt 3 cycles -> stays all-ones.
//     rst=0 mid-flush -> next cycle state=RUN, taken_branch=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and decode helpers for the pipeline hazard controller.
//   - XLEN          : instruction width seen by decode
//   - OPC_*         : RV32I major opcodes used by the hazard decode
//   - ctrl_state_e  : controller FSM state {RUN, FLUSH}
//   - trk_entry_t   : one in-flight destination tracker entry {valid, rd, is_load}
//   - uses_rs1 / uses_rs2 / writes_rd : register usage by opcode
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } trk_entry_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_JALR: return 1'b1;
            default:                                                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_BRANCH, OPC_STORE: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD: return 1'b1;
            default:                                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Three-entry tracker of in-flight destination registers (EX, MEM, WB) and
//   the compare against the source registers of the instruction in decode.
//   Build option HAZARD_FORWARD_EN: when defined, an EX/MEM bypass is assumed
//   and only a load in EX feeding decode is a hazard; otherwise any match in
//   EX, MEM or WB is a hazard.
// Ports
//   clk      in   core clock
//   rst      in   synchronous active-low reset, clears all entries
//   id_instr in   instruction currently in decode
//   advance  in   shift EX->MEM->WB->drop this cycle (low while memory is busy)
//   ex_load  in   decode instruction enters EX this cycle (else EX gets a bubble)
//   hazard   out  a used source of id_instr matches a tracked destination
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] id_instr,
    input  logic            advance,
    input  logic            ex_load,
    output logic            hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign use1   = uses_rs1(opcode);
    assign use2   = uses_rs2(opcode);

    trk_entry_t ex_q, mem_q, wb_q, ex_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ex_d         = '0;
        ex_d.valid   = ex_load & writes_rd(opcode);
        ex_d.rd      = rd;
        ex_d.is_load = (opcode == OPC_LOAD);
    end

    // NOTE: sequential state uses non-blocking assignments so the three
    // entries shift together on the same edge instead of collapsing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (advance) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // x0 is hard-wired zero, so reading it never waits on a producer.
    function automatic logic hit(input trk_entry_t e, input logic [4:0] rs);
        return e.valid && (e.rd == rs) && (rs != 5'd0);
    endfunction

`ifdef HAZARD_FORWARD_EN
    assign hazard = ex_q.is_load & ((use1 & hit(ex_q, rs1)) | (use2 & hit(ex_q, rs2)));
`else
    assign hazard = (use1 & (hit(ex_q, rs1) | hit(mem_q, rs1) | hit(wb_q, rs1)))
                  | (use2 & (hit(ex_q, rs2) | hit(mem_q, rs2) | hit(wb_q, rs2)));
`endif

    // Instruction fields and tracker bits that no hazard rule looks at.
    logic unused_bits;
    assign unused_bits = ^{id_instr[31:25], id_instr[14:12], mem_q, wb_q};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline controller for the 5-stage core: generates halt (stall) and
//   taken_branch (flush), sequences multi-cycle branch flushes and memory-busy
//   freezes, and counts stalled cycles.
//   Build option HAZARD_FORWARD_EN selects load-use-only hazards (see
//   hazard_scoreboard).
// Parameters
//   FLUSH_CYCLES  cycles taken_branch is held after a taken branch (1..7)
//   CNT_W         width of the saturating stall_cycles counter
// Ports
//   clk           in   core clock
//   rst           in   synchronous active-low reset
//   id_instr      in   instruction in decode
//   id_valid      in   id_instr is real (0 = bubble)
//   ex_branch_en  in   execute resolved a taken branch/jump this cycle
//   mem_busy      in   data memory not ready; freeze the whole pipe
//   halt          out  stall fetch/decode/execute (combinational)
//   taken_branch  out  kill younger instructions (decoded from state)
//   ex_bubble     out  a bubble enters EX this cycle
//   stall_cycles  out  saturating count of cycles with halt=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  id_instr,
    input  logic             id_valid,
    input  logic             ex_branch_en,
    input  logic             mem_busy,
    output logic             halt,
    output logic             taken_branch,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        hazard;
    logic        ex_load;
    logic        in_flush;

    assign in_flush = (state_q == FLUSH);

    // A hazard keeps decode out of EX; the branch still moves the FSM to
    // FLUSH, so the stalled instruction is killed rather than replayed.
    assign ex_load = id_valid & ~hazard & (state_q == RUN);

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .id_instr (id_instr),
        .advance  (~mem_busy),
        .ex_load  (ex_load),
        .hazard   (hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_busy freezes state and counter; branches arriving in FLUSH belong
    // to instructions that are being killed and are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mem_busy) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_en) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // While reset is asserted the registered state may still be stale, so
    // the state-derived terms are masked and only mem_busy reaches halt.
    assign halt         = mem_busy
                        | (rst & (((state_q == RUN) & id_valid & hazard) | in_flush));
    assign taken_branch = rst & in_flush;
    assign ex_bubble    = rst & ~mem_busy & ((id_valid & ~ex_load) | in_flush);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (halt && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
